qs_srt_decode: RTL

Registered decode stage for the sort-engine microsequencer. Accepts 16-bit `inst_t` words with their PC from the fetch stage and emits the horizontal `ucode_t` plus PC to execute. Valid/ready on both sides, one-cycle latency, flush on `kill`. An optional interlock inserts a bubble after a `pop` whose destination is read by the following instruction.

---
 rtl/qs_srt_pkg.sv | 123 ++++++++++++
 rtl/qs_srt_decode.sv | 79 +++++++
 2 files changed

// File: rtl/qs_srt_pkg.sv
// qs_srt_pkg: shared types and the combinational instruction decoder for the sort-engine microsequencer
package qs_srt_pkg;

    typedef logic [15:0] inst_t;
    typedef logic [7:0]  pc_t;
    typedef logic [2:0]  reg_t;

    typedef enum logic [1:0] {CC_AL, CC_EQ, CC_NE, CC_LT} cc_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_JCC   = 4'h1,
        OP_PP    = 4'h2,
        OP_MEM   = 4'h4,
        OP_MOV   = 4'h6,
        OP_ARITH = 4'h7,
        OP_CRET  = 4'hC,
        OP_CNTRL = 4'hF
    } opcode_t;

    localparam reg_t BLINK = 3'd7;

    typedef struct packed {
        logic       invalid_inst;
        logic       is_jump;
        cc_t        cc;
        pc_t        target;
        logic       is_pop;
        logic       is_push;
        logic       is_load;
        logic       is_store;
        logic       is_call;
        logic       is_ret;
        logic       is_await;
        logic       is_done;
        logic       dst_en;
        reg_t       dst;
        logic       dst_is_blink;
        logic       src0_en;
        reg_t       src0;
        logic       src0_is_zero;
        logic       src1_en;
        reg_t       src1;
        logic       inv_src1;
        logic       has_imm;
        logic [2:0] imm;
        logic       has_special;
        logic [2:0] special;
        logic       flag_en;
        logic       cin;
    } ucode_t;

    // Expand one fetch word into horizontal microcode; unknown opcodes only raise invalid_inst
    function automatic ucode_t decode(inst_t inst);
        ucode_t u;
        u = '0;
        case (inst[15:12])
            OP_NOP: ;
            OP_JCC: begin
                u.is_jump = 1'b1;
                u.cc      = cc_t'(inst[9:8]);
                u.target  = inst[7:0];
            end
            OP_PP: begin
                u.is_pop  = inst[11];
                u.is_push = !inst[11];
                u.dst_en  = inst[11];
                u.dst     = inst[11] ? inst[10:8] : '0;
                u.src1_en = !inst[11];
                u.src1    = inst[11] ? '0 : inst[2:0];
            end
            OP_MEM: begin
                u.is_store = inst[11];
                u.is_load  = !inst[11];
                u.src0_en  = inst[11];
                u.src0     = inst[11] ? inst[6:4] : '0;
                u.dst_en   = !inst[11];
                u.dst      = inst[11] ? '0 : inst[10:8];
                u.src1_en  = 1'b1;
                u.src1     = inst[2:0];
            end
            OP_MOV: begin
                u.dst_en       = 1'b1;
                u.dst          = inst[10:8];
                u.src0_is_zero = 1'b1;
                u.has_special  = inst[11];
                u.special      = inst[11] ? inst[2:0] : '0;
                u.has_imm      = !inst[11] && inst[3];
                u.imm          = (!inst[11] && inst[3]) ? inst[2:0] : '0;
                u.src1_en      = !inst[11] && !inst[3];
                u.src1         = (!inst[11] && !inst[3]) ? inst[2:0] : '0;
            end
            OP_ARITH: begin
                u.dst_en   = inst[7];
                u.dst      = inst[10:8];
                u.src0_en  = 1'b1;
                u.src0     = inst[6:4];
                u.flag_en  = 1'b1;
                u.has_imm  = inst[3];
                u.imm      = inst[3] ? inst[2:0] : '0;
                u.src1_en  = !inst[3];
                u.src1     = inst[3] ? '0 : inst[2:0];
                u.inv_src1 = inst[11];
                u.cin      = inst[11];
            end
            OP_CRET: begin
                u.is_ret       = inst[11];
                u.is_call      = !inst[11];
                u.target       = inst[11] ? '0 : inst[7:0];
                u.dst_en       = !inst[11];
                u.dst          = inst[11] ? '0 : BLINK;
                u.dst_is_blink = !inst[11];
            end
            OP_CNTRL: begin
                u.is_done  = inst[11];
                u.is_await = !inst[11];
            end
            default: u.invalid_inst = 1'b1;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/qs_srt_decode.sv
// qs_srt_decode: registered decode stage, valid/ready both sides, kill flush; optional pop interlock via QS_SRT_DECODE_POP_INTERLOCK_EN
module qs_srt_decode
    import qs_srt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [15:0] in_inst,
    input  logic [7:0]  in_pc,
    output logic        in_rdy,
    output logic        out_vld,
    output ucode_t      out_ucode,
    output logic [7:0]  out_pc,
    input  logic        out_rdy,
    input  logic        kill
);

    ucode_t dec;
    ucode_t ucode_q, ucode_d;
    pc_t    pc_q, pc_d;
    logic   vld_q, vld_d;
    logic   load, hazard, take;

    assign dec       = decode(in_inst);
    assign load      = !vld_q || out_rdy;
    assign in_rdy    = load && !hazard;
    assign take      = in_vld && in_rdy && !kill;
    assign out_vld   = vld_q;
    assign out_ucode = ucode_q;
    assign out_pc    = pc_q;

    // Output register: capture on transfer, drop valid on an empty load or on kill, otherwise hold
    always_comb begin
        vld_d   = kill ? 1'b0 : (load ? take : vld_q);
        ucode_d = take ? dec : ucode_q;
        pc_d    = take ? in_pc : pc_q;
    end

    // Output register state
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            ucode_q <= '0;
            pc_q    <= '0;
        end else begin
            vld_q   <= vld_d;
            ucode_q <= ucode_d;
            pc_q    <= pc_d;
        end
    end

`ifdef QS_SRT_DECODE_POP_INTERLOCK_EN
    logic pend_q, pend_d;
    reg_t pend_reg_q, pend_reg_d;

    assign hazard = pend_q && in_vld && load &&
                    ((dec.src0_en && dec.src0 == pend_reg_q) || (dec.src1_en && dec.src1 == pend_reg_q));

    // Remember a pop sitting in the output register; any other load, including a bubble, forgets it
    always_comb begin
        pend_d     = kill ? 1'b0 : (load ? (take && dec.is_pop) : pend_q);
        pend_reg_d = kill ? '0 : (load ? ((take && dec.is_pop) ? dec.dst : '0) : pend_reg_q);
    end

    // Interlock state
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_reg_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_reg_q <= pend_reg_d;
        end
    end
`else
    assign hazard = 1'b0;
`endif

endmodule
